// File: rtl/control_sequencer.sv
// control_sequencer: accepts 23-bit instruction words from a valid/ready
// handshake and walks a fixed sequence of execute steps for each one.
//   clk, rst_n (sync, active-low), run, ir_valid, ir[22:0] -> inputs
//   ir_ready, state[4:0], inst_reg[22:0], alu_op[1:0], done, illegal,
//   halted, retired[15:0]                                  -> outputs
module control_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        ir_valid,
  input  logic [22:0] ir,
  output logic        ir_ready,
  output logic [4:0]  state,
  output logic [22:0] inst_reg,
  output logic [1:0]  alu_op,
  output logic        done,
  output logic        illegal,
  output logic        halted,
  output logic [15:0] retired
);

  typedef enum logic [4:0] {
    FETCH    = 5'b00000,
    LOAD     = 5'b00001,
    MOV      = 5'b00010,
    ARITH_A  = 5'b00011,
    ARITH_G  = 5'b00100,
    ARITH_WB = 5'b00101,
    HALT     = 5'b11111
  } state_t;

  state_t cur_state, nxt_state;
  logic   accept;
  logic   illegal_nxt;

  assign state = cur_state;

  always_comb begin
    nxt_state   = cur_state;
    ir_ready    = 1'b0;
    accept      = 1'b0;
    illegal_nxt = 1'b0;
    done        = 1'b0;
    alu_op      = 2'b00;
    halted      = 1'b0;
    case (cur_state)
      FETCH: begin
        // rst_n gates ready so nothing is offered during the reset cycle
        ir_ready = run & rst_n;
        accept   = ir_valid & ir_ready;
        if (accept) begin
          case (ir[22:20])
            3'b000:         nxt_state = LOAD;
            3'b001:         nxt_state = MOV;
            3'b010, 3'b011: nxt_state = ARITH_A;
            3'b111:         nxt_state = HALT;
            default: begin
              nxt_state   = FETCH;
              illegal_nxt = 1'b1;
            end
          endcase
        end
      end
      LOAD:     begin nxt_state = FETCH;    done = 1'b1; end
      MOV:      begin nxt_state = FETCH;    done = 1'b1; end
      ARITH_A:  nxt_state = ARITH_G;
      ARITH_G:  begin
        nxt_state = ARITH_WB;
        alu_op    = {1'b0, inst_reg[20]};
      end
      ARITH_WB: begin nxt_state = FETCH;    done = 1'b1; end
      HALT:     begin nxt_state = HALT;     halted = 1'b1; end
      default:  nxt_state = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= FETCH;
      inst_reg  <= '0;
      illegal   <= 1'b0;
      retired   <= '0;
    end else begin
      cur_state <= nxt_state;
      illegal   <= illegal_nxt;
      if (accept)
        inst_reg <= ir;
      if (done)
        retired <= retired + 16'd1;
    end
  end

endmodule
